// File: rtl/branch_pkg.sv
// Shared types, PC-select codes, flag bit positions and helpers for the
// execute-stage branch unit and its direction predictor.
package branch_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_B     = 3'd1,
    OP_BR    = 3'd2,
    OP_BL    = 3'd3,
    OP_CBZ   = 3'd4,
    OP_CBNZ  = 3'd5,
    OP_BCOND = 3'd6
  } branch_op_t;

  typedef enum logic [3:0] {
    C_EQ = 4'd0,  C_NE = 4'd1,  C_HS = 4'd2,  C_LO = 4'd3,
    C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
    C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
    C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
  } cond_t;

  localparam logic [1:0] PCPLUS4  = 2'd0;
  localparam logic [1:0] PCBRANCH = 2'd1;
  localparam logic [1:0] PCALUOUT = 2'd2;

  // Bit positions inside the {N,Z,C,V} flags vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition evaluation; NV is treated as never-taken here.
  function automatic logic eval_cond(cond_t c, logic [3:0] f);
    logic n, z, cy, v;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cy = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      C_EQ:    return z;
      C_NE:    return ~z;
      C_HS:    return cy;
      C_LO:    return ~cy;
      C_MI:    return n;
      C_PL:    return ~n;
      C_VS:    return v;
      C_VC:    return ~v;
      C_HI:    return cy & ~z;
      C_LS:    return ~cy | z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return ~z & (n == v);
      C_LE:    return z | (n != v);
      C_AL:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 2-bit saturating counter step.
  function automatic logic [1:0] ctr_step(logic [1:0] c, logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    else    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: DEPTH 2-bit saturating counters, one combinational
// read port for fetch and one write (train) port for execute.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [2*DEPTH-1:0] w_ctr_flat;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [1:0] r_ctr;
    // Each entry resets to weakly-not-taken and steps only when trained.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
        r_ctr <= 2'b01;
      else if (i_we && (i_wr_idx == IDX_W'(gi)))
        r_ctr <= ctr_step(r_ctr, i_wr_taken);
    end
    assign w_ctr_flat[2*gi +: 2] = r_ctr;
  end

  // Read shows the stored (pre-update) value; no write bypass.
  assign o_rd_ctr = w_ctr_flat[{i_rd_idx, 1'b0} +: 2];

endmodule

// File: rtl/branch_unit_bp.sv
// Execute-stage branch resolution with NZCV register, BHT-based direction
// prediction for fetch, mispredict detection and saturating statistics.
module branch_unit_bp
  import branch_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DEPTH    = 64,
  parameter int FLAG_FWD = 1,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_fetch_pc,
  output logic              o_pred_taken,
  input  logic              i_ex_valid,
  input  logic [ADDR_W-1:0] i_ex_pc,
  input  logic [2:0]        i_branch_op,
  input  logic [3:0]        i_cond,
  input  logic              i_ex_pred_taken,
  input  logic              i_alu_zero,
  input  logic              i_setflags,
  input  logic [3:0]        i_flags_in,
  output logic [3:0]        o_flags_q,
  output logic [1:0]        o_branch,
  output logic              o_taken,
  output logic              o_mispredict,
  output logic [CNT_W-1:0]  o_br_count,
  output logic [CNT_W-1:0]  o_mp_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;
  logic [3:0]       w_flags_eff;
  logic [1:0]       w_sel;
  logic             w_is_cond;
  logic             w_taken;
  logic             w_mispredict;
  logic [1:0]       w_rd_ctr;
  logic             w_unused;

  // Only the index slice of each PC feeds the table.
  assign w_unused = ^{i_fetch_pc, i_ex_pc};

  assign w_flags_eff = ((FLAG_FWD != 0) && i_setflags) ? i_flags_in : r_flags;

  // Resolve PC select and classify conditional ops; everything idles to 0.
  always_comb begin
    w_sel     = PCPLUS4;
    w_is_cond = 1'b0;
    if (i_ex_valid && !i_reset) begin
      case (branch_op_t'(i_branch_op))
        OP_B, OP_BL: w_sel = PCBRANCH;
        OP_BR:       w_sel = PCALUOUT;
        OP_CBZ: begin
          w_sel     = i_alu_zero ? PCBRANCH : PCPLUS4;
          w_is_cond = 1'b1;
        end
        OP_CBNZ: begin
          w_sel     = i_alu_zero ? PCPLUS4 : PCBRANCH;
          w_is_cond = 1'b1;
        end
        OP_BCOND: begin
          w_sel     = eval_cond(cond_t'(i_cond), w_flags_eff) ? PCBRANCH : PCPLUS4;
          w_is_cond = (cond_t'(i_cond) != C_AL) && (cond_t'(i_cond) != C_NV);
        end
        default: w_sel = PCPLUS4;
      endcase
    end
  end

  assign w_taken      = (w_sel != PCPLUS4);
  assign w_mispredict = w_is_cond & (w_taken ^ i_ex_pred_taken);

  assign o_branch     = w_sel;
  assign o_taken      = w_taken;
  assign o_mispredict = w_mispredict;
  assign o_flags_q    = r_flags;
  assign o_br_count   = r_br_cnt;
  assign o_mp_count   = r_mp_cnt;
  assign o_pred_taken = w_rd_ctr[1];

  // Architectural flags register, written by valid flag-setting instructions.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_flags <= 4'd0;
    else if (i_ex_valid && i_setflags)
      r_flags <= i_flags_in;
  end

  // Statistics counters that stick at all-ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_is_cond && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_mispredict && (r_mp_cnt != '1))
        r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  bht_2bit #(.DEPTH(DEPTH)) u_bht (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_idx   (i_fetch_pc[2 +: IDX_W]),
    .o_rd_ctr   (w_rd_ctr),
    .i_we       (w_is_cond),
    .i_wr_idx   (i_ex_pc[2 +: IDX_W]),
    .i_wr_taken (w_taken)
  );

endmodule

// File: tb/tb_branch_unit_bp.sv
// Randomised and directed bench for branch_unit_bp. Two instances share the
// stimulus: index 0 forwards flags (32-bit counters), index 1 does not
// (4-bit counters so saturation is reachable).
module tb_branch_unit_bp;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] fetch_pc, ex_pc;
  logic        ex_valid, ex_pred_taken, alu_zero, setflags;
  logic [2:0]  branch_op;
  logic [3:0]  cond, flags_in;

  logic        pred [2];
  logic [3:0]  flq [2];
  logic [1:0]  brs [2];
  logic        tk [2];
  logic        mp [2];
  logic [31:0] brc0, mpc0;
  logic [3:0]  brc1, mpc1;

  int n_vec = 0;
  int n_err = 0;

  // Reference state.
  int          m_bht [2][DEPTH];
  logic [3:0]  m_fl [2];
  longint      m_brc [2], m_mpc [2];
  longint      m_cmax [2];

  // Captured per-cycle observations for directed checks.
  logic [1:0]  obs_br [2];
  logic        obs_tk [2], obs_mp [2];

  always #5 clk = ~clk;

  branch_unit_bp #(.ADDR_W(64), .DEPTH(DEPTH), .FLAG_FWD(1), .CNT_W(32)) u_fwd (
    .i_clk(clk), .i_reset(rst), .i_fetch_pc(fetch_pc), .o_pred_taken(pred[0]),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_branch_op(branch_op), .i_cond(cond),
    .i_ex_pred_taken(ex_pred_taken), .i_alu_zero(alu_zero), .i_setflags(setflags),
    .i_flags_in(flags_in), .o_flags_q(flq[0]), .o_branch(brs[0]), .o_taken(tk[0]),
    .o_mispredict(mp[0]), .o_br_count(brc0), .o_mp_count(mpc0));

  branch_unit_bp #(.ADDR_W(64), .DEPTH(DEPTH), .FLAG_FWD(0), .CNT_W(4)) u_nof (
    .i_clk(clk), .i_reset(rst), .i_fetch_pc(fetch_pc), .o_pred_taken(pred[1]),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_branch_op(branch_op), .i_cond(cond),
    .i_ex_pred_taken(ex_pred_taken), .i_alu_zero(alu_zero), .i_setflags(setflags),
    .i_flags_in(flags_in), .o_flags_q(flq[1]), .o_branch(brs[1]), .o_taken(tk[1]),
    .o_mispredict(mp[1]), .o_br_count(brc1), .o_mp_count(mpc1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [63:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [63:0] get_brc(input int m);
    return (m == 0) ? {32'd0, brc0} : {60'd0, brc1};
  endfunction

  function automatic logic [63:0] get_mpc(input int m);
    return (m == 0) ? {32'd0, mpc0} : {60'd0, mpc1};
  endfunction

  // ARM condition truth table, flags given as {N,Z,C,V}.
  function automatic bit ref_cond(input int c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;           1: return !z;
      2: return cy;          3: return !cy;
      4: return n;           5: return !n;
      6: return v;           7: return !v;
      8: return cy && !z;    9: return !cy || z;
      10: return n == v;     11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < DEPTH; i++) m_bht[m][i] = 1;
      m_fl[m] = 4'd0;
      m_brc[m] = 0;
      m_mpc[m] = 0;
    end
  endtask

  // One execute cycle: drive, check combinational results, clock, check state.
  task automatic cycle(input bit v, input logic [63:0] epc, input logic [63:0] fpc,
                       input int op, input int c, input bit pt, input bit az,
                       input bit sf, input logic [3:0] fi);
    int  e_sel [2];
    bit  e_cond [2], e_tk [2], e_mp [2];
    logic [3:0] feff;
    @(negedge clk);
    ex_valid = v; ex_pc = epc; fetch_pc = fpc; branch_op = 3'(op); cond = 4'(c);
    ex_pred_taken = pt; alu_zero = az; setflags = sf; flags_in = fi;
    #1;
    for (int m = 0; m < 2; m++) begin
      feff = (m == 0 && sf) ? fi : m_fl[m];
      e_sel[m] = 0; e_cond[m] = 0;
      if (v) begin
        case (op)
          1, 3: e_sel[m] = 1;
          2:    e_sel[m] = 2;
          4:    begin e_sel[m] = az ? 1 : 0;  e_cond[m] = 1; end
          5:    begin e_sel[m] = az ? 0 : 1;  e_cond[m] = 1; end
          6:    begin e_sel[m] = ref_cond(c, feff) ? 1 : 0; e_cond[m] = (c < 14); end
          default: e_sel[m] = 0;
        endcase
      end
      e_tk[m] = (e_sel[m] != 0);
      e_mp[m] = e_cond[m] && (e_tk[m] != pt);
      check($sformatf("branch[%0d]", m), 64'(brs[m]), 64'(e_sel[m]));
      check($sformatf("taken[%0d]", m), 64'(tk[m]), 64'(e_tk[m]));
      check($sformatf("mispredict[%0d]", m), 64'(mp[m]), 64'(e_mp[m]));
      check($sformatf("pred_pre[%0d]", m), 64'(pred[m]), 64'(m_bht[m][idx(fpc)] >= 2));
      obs_br[m] = brs[m]; obs_tk[m] = tk[m]; obs_mp[m] = mp[m];
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (v && sf) m_fl[m] = fi;
      if (e_cond[m]) begin
        if (e_tk[m]) m_bht[m][idx(epc)] = (m_bht[m][idx(epc)] < 3) ? m_bht[m][idx(epc)] + 1 : 3;
        else         m_bht[m][idx(epc)] = (m_bht[m][idx(epc)] > 0) ? m_bht[m][idx(epc)] - 1 : 0;
        if (m_brc[m] < m_cmax[m]) m_brc[m]++;
      end
      if (e_mp[m] && m_mpc[m] < m_cmax[m]) m_mpc[m]++;
      check($sformatf("flags_q[%0d]", m), 64'(flq[m]), 64'(m_fl[m]));
      check($sformatf("br_count[%0d]", m), get_brc(m), 64'(m_brc[m]));
      check($sformatf("mp_count[%0d]", m), get_mpc(m), 64'(m_mpc[m]));
      check($sformatf("pred_post[%0d]", m), 64'(pred[m]), 64'(m_bht[m][idx(fpc)] >= 2));
    end
  endtask

  // Reset asserted between clock edges while a conditional op is presented.
  task automatic reset_mid(input logic [63:0] fpc);
    @(negedge clk);
    ex_valid = 1; branch_op = 3'd4; alu_zero = 1; ex_pc = fpc; fetch_pc = fpc;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_flags[%0d]", m), 64'(flq[m]), 64'd0);
      check($sformatf("rst_brc[%0d]", m), get_brc(m), 64'd0);
      check($sformatf("rst_mpc[%0d]", m), get_mpc(m), 64'd0);
      check($sformatf("rst_branch[%0d]", m), 64'(brs[m]), 64'd0);
      check($sformatf("rst_pred[%0d]", m), 64'(pred[m]), 64'd0);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    ex_valid = 0;
  endtask

  function automatic logic [63:0] pick_pc();
    case ($urandom_range(0, 4))
      0: return 64'h40;
      1: return 64'h140;
      2: return 64'h44;
      3: return 64'h240;
      default: return {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
    endcase
  endfunction

  initial begin
    m_cmax[0] = 64'hFFFF_FFFF;
    m_cmax[1] = 15;
    rst = 1'b1;
    ex_valid = 0; ex_pc = 0; fetch_pc = 64'h1234_5678_9ABC_DEF0; branch_op = 0; cond = 0;
    ex_pred_taken = 0; alu_zero = 0; setflags = 0; flags_in = 0;
    model_reset();
    #12;
    // Reset state.
    for (int m = 0; m < 2; m++) begin
      check($sformatf("init_pred[%0d]", m), 64'(pred[m]), 64'd0);
      check($sformatf("init_flags[%0d]", m), 64'(flq[m]), 64'd0);
      check($sformatf("init_brc[%0d]", m), get_brc(m), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // SUBS setting Z, then B.EQ predicted not-taken.
    cycle(1, 64'h100, 64'h100, 0, 0, 0, 0, 1, 4'b0100);
    check("t2_flags", 64'(flq[1]), 64'h4);
    cycle(1, 64'h104, 64'h104, 6, 0, 0, 0, 0, 4'b0000);
    check("t2_branch", 64'(obs_br[1]), 64'd1);
    check("t2_taken", 64'(obs_tk[1]), 64'd1);
    check("t2_mispred", 64'(obs_mp[1]), 64'd1);
    check("t2_mp_count", get_mpc(1), 64'd1);

    // Forwarding: clear flags, then set Z and B.NE in the same cycle.
    cycle(1, 64'h108, 64'h108, 0, 0, 0, 0, 1, 4'b0000);
    cycle(1, 64'h10C, 64'h10C, 6, 1, 0, 0, 1, 4'b0100);
    check("t3_branch_fwd", 64'(obs_br[0]), 64'd0);
    check("t3_branch_nofwd", 64'(obs_br[1]), 64'd1);
    check("t3_flags_next", 64'(flq[0]), 64'h4);

    // Training and saturation at 0x40.
    reset_mid(64'h40);
    cycle(1, 64'h40, 64'h40, 4, 0, 0, 1, 0, 4'd0);
    check("t4_pred_after1", 64'(pred[0]), 64'd1);
    cycle(1, 64'h40, 64'h40, 4, 0, 1, 1, 0, 4'd0);
    cycle(1, 64'h40, 64'h40, 4, 0, 1, 1, 0, 4'd0);
    cycle(1, 64'h40, 64'h40, 4, 0, 1, 0, 0, 4'd0);
    check("t4_pred_nt1", 64'(pred[0]), 64'd1);
    cycle(1, 64'h40, 64'h40, 4, 0, 1, 0, 0, 4'd0);
    check("t4_pred_nt2", 64'(pred[0]), 64'd0);

    // Aliasing: 0x140 trains the counter that fetch of 0x40 reads.
    reset_mid(64'h40);
    cycle(1, 64'h140, 64'h40, 5, 0, 0, 0, 0, 4'd0);
    check("t5_same_cycle_old", 64'(obs_tk[0]) & 64'(pred[0]), 64'd1);
    check("t5_alias_pred", 64'(pred[1]), 64'd1);

    // Every condition against every NZCV value, plus BR.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        cycle(1, 64'(f * 4), 64'(c * 4), 6, c, $urandom_range(0, 1), 0, 1, 4'(f));
        check($sformatf("t6_cond%0d_f%0h", c, f), 64'(obs_tk[0]), 64'(ref_cond(c, 4'(f))));
      end
    end
    cycle(1, 64'h200, 64'h200, 2, 0, 1, 0, 0, 4'd0);
    check("t6_br_sel", 64'(obs_br[0]), 64'd2);
    check("t6_br_mp", 64'(obs_mp[0]), 64'd0);

    // Reset in the middle of training.
    cycle(1, 64'h40, 64'h40, 4, 0, 0, 1, 0, 4'd0);
    cycle(1, 64'h40, 64'h40, 4, 0, 1, 1, 0, 4'd0);
    reset_mid(64'h40);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 85, pick_pc(), pick_pc(), $urandom_range(0, 6),
            $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), 4'($urandom_range(0, 15)));
    end
    check("sat_brc_small", get_brc(1), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
